// File: rtl/adpll_loop_ctrl.sv
// ADPLL digital loop controller: SAR coarse acquisition of the DCO code, then
// bang-bang +/-1 LSB tracking with lock/unlock detection. Any M change restarts acquisition.
module adpll_loop_ctrl #(
    parameter int CODE_W     = 8,
    parameter int SETTLE_CYC = 4,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic              REF_CLK,
    input  logic              RESET,
    input  logic [2:0]        M,
    input  logic              PFD_UP,
    input  logic              PFD_DN,
    output logic [CODE_W-1:0] DCO_CODE,
    output logic              freq_lock,
    output logic              SAR_DONE
);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int LCK_W = $clog2(LOCK_CNT + 1);
    localparam int RUN_W = $clog2(UNLOCK_CNT + 1);
    localparam int IDX_W = $clog2(CODE_W);

    localparam logic [CODE_W-1:0] CODE_MID    = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] CODE_MAX    = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_MIN    = {CODE_W{1'b0}};
    localparam logic [CODE_W-1:0] CODE_ONE    = {{(CODE_W-1){1'b0}}, 1'b1};
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [LCK_W-1:0]  LOCK_FULL   = LCK_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0]  RUN_FULL    = RUN_W'(UNLOCK_CNT);
    localparam logic [IDX_W-1:0]  IDX_TOP     = IDX_W'(CODE_W - 1);

    typedef enum logic [0:0] {ST_SAR = 1'b0, ST_TRACK = 1'b1} state_e;
    typedef enum logic [1:0] {DIR_NONE = 2'b00, DIR_UP = 2'b01, DIR_DN = 2'b10} dir_e;

    state_e            state_q, state_d;
    dir_e              dir_q, dir_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [LCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              lock_q, lock_d;
    logic              done_q, done_d;
    logic [2:0]        m_q;

    logic fast_s, slow_s, due_s, m_chg_s, same_dir_s;

    assign fast_s  = PFD_DN & ~PFD_UP;
    assign slow_s  = PFD_UP & ~PFD_DN;
    assign due_s   = (settle_q == SETTLE_LAST);
    assign m_chg_s = (M != m_q);
    // With no previous step, any step counts as a same-direction run.
    assign same_dir_s = (slow_s & (dir_q != DIR_DN)) | (fast_s & (dir_q != DIR_UP));

    // State register
    always_ff @(posedge REF_CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_SAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (m_chg_s) begin
            state_d = ST_SAR;
        end else if (due_s) begin
            case (state_q)
                ST_SAR:   state_d = (idx_q == {IDX_W{1'b0}}) ? ST_TRACK : ST_SAR;
                ST_TRACK: state_d = ST_TRACK;
                default:  state_d = ST_SAR;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Datapath next values: SAR bit trials, tracking steps, lock bookkeeping
    always_comb begin
        code_d     = code_q;
        idx_d      = idx_q;
        settle_d   = due_s ? {SET_W{1'b0}} : settle_q + SET_W'(1);
        lock_cnt_d = lock_cnt_q;
        run_d      = run_q;
        dir_d      = dir_q;
        lock_d     = lock_q;
        done_d     = done_q;
        if (m_chg_s) begin
            code_d     = CODE_MID;
            idx_d      = IDX_TOP;
            settle_d   = {SET_W{1'b0}};
            lock_cnt_d = {LCK_W{1'b0}};
            run_d      = {RUN_W{1'b0}};
            dir_d      = DIR_NONE;
            lock_d     = 1'b0;
            done_d     = 1'b0;
        end else if (due_s) begin
            case (state_q)
                ST_SAR: begin
                    if (fast_s) begin
                        code_d[idx_q] = 1'b0;
                    end else begin
                        code_d[idx_q] = code_q[idx_q];
                    end
                    if (idx_q != {IDX_W{1'b0}}) begin
                        code_d[idx_q - IDX_W'(1)] = 1'b1;
                        idx_d = idx_q - IDX_W'(1);
                    end else begin
                        done_d = 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (slow_s) begin
                        code_d = (code_q == CODE_MAX) ? code_q : code_q + CODE_ONE;
                        dir_d  = DIR_UP;
                    end else if (fast_s) begin
                        code_d = (code_q == CODE_MIN) ? code_q : code_q - CODE_ONE;
                        dir_d  = DIR_DN;
                    end else begin
                        code_d = code_q;
                        dir_d  = dir_q;
                    end
                    if (same_dir_s) begin
                        run_d      = (run_q == RUN_FULL) ? run_q : run_q + RUN_W'(1);
                        lock_cnt_d = {LCK_W{1'b0}};
                        lock_d     = (run_d == RUN_FULL) ? 1'b0 : lock_q;
                    end else begin
                        lock_cnt_d = (lock_cnt_q == LOCK_FULL) ? lock_cnt_q : lock_cnt_q + LCK_W'(1);
                        run_d      = {RUN_W{1'b0}};
                        lock_d     = (lock_cnt_d == LOCK_FULL) ? 1'b1 : lock_q;
                    end
                end
                default: begin
                    code_d = CODE_MID;
                    idx_d  = IDX_TOP;
                end
            endcase
        end else begin
            code_d = code_q;
        end
    end

    // Datapath registers; M is captured during reset so release is not seen as a change
    always_ff @(posedge REF_CLK or posedge RESET) begin
        if (RESET) begin
            code_q     <= CODE_MID;
            idx_q      <= IDX_TOP;
            settle_q   <= {SET_W{1'b0}};
            lock_cnt_q <= {LCK_W{1'b0}};
            run_q      <= {RUN_W{1'b0}};
            dir_q      <= DIR_NONE;
            lock_q     <= 1'b0;
            done_q     <= 1'b0;
            m_q        <= M;
        end else begin
            code_q     <= code_d;
            idx_q      <= idx_d;
            settle_q   <= settle_d;
            lock_cnt_q <= lock_cnt_d;
            run_q      <= run_d;
            dir_q      <= dir_d;
            lock_q     <= lock_d;
            done_q     <= done_d;
            m_q        <= M;
        end
    end

    assign DCO_CODE  = code_q;
    assign freq_lock = lock_q;
    assign SAR_DONE  = done_q;
endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// Bench for adpll_loop_ctrl: scenario table plus randomized traffic, all checked every
// edge against an edge-count based reference model of the loop rules.
module tb_adpll_loop_ctrl;
    localparam int CODE_W   = 8;
    localparam int SETTLE   = 4;
    localparam int LOCK_N   = 8;
    localparam int UNLOCK_N = 4;

    localparam int MODE_SLOW   = 0;
    localparam int MODE_TARGET = 1;
    localparam int MODE_DITHER = 2;
    localparam int MODE_BOTH   = 3;
    localparam int MODE_RANDOM = 4;

    localparam int RS_NONE  = 0;
    localparam int RS_RESET = 1;
    localparam int RS_MCHG  = 2;

    typedef struct {
        int restart;
        int new_m;
        int mode;
        int target;
        int cycles;
        int chk_end;
        int exp_code;
        int exp_lock;
        int exp_done;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] m_s;
    logic       up_s, dn_s;
    logic [7:0] code_o;
    logic       lock_o, done_o;

    always #5 clk = ~clk;

    adpll_loop_ctrl #(.CODE_W(CODE_W), .SETTLE_CYC(SETTLE), .LOCK_CNT(LOCK_N), .UNLOCK_CNT(UNLOCK_N)) dut (
        .REF_CLK  (clk),
        .RESET    (rst),
        .M        (m_s),
        .PFD_UP   (up_s),
        .PFD_DN   (dn_s),
        .DCO_CODE (code_o),
        .freq_lock(lock_o),
        .SAR_DONE (done_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: r_k counts edges since the last restart; decisions fall on multiples of SETTLE.
    int r_k, r_code, r_lock_cnt, r_run, r_dir, r_mq;
    bit r_lock, r_done, r_eval;
    bit dither_up;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int m);
        r_k        = 0;
        r_code     = 128;
        r_lock_cnt = 0;
        r_run      = 0;
        r_dir      = 0;
        r_lock     = 1'b0;
        r_done     = 1'b0;
        r_mq       = m;
    endtask

    task automatic model_edge(input int m, input bit up, input bit dn);
        int  dec;
        int  b;
        bit  same;
        r_eval = 1'b0;
        dec = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
        if (m != r_mq) begin
            model_reset(m);
            return;
        end
        r_k++;
        if (r_k % SETTLE != 0) return;
        r_eval = 1'b1;
        if (!r_done) begin
            b = CODE_W - r_k / SETTLE;
            if (dec == -1) r_code -= (1 << b);
            if (b > 0) r_code += (1 << (b - 1));
            else r_done = 1'b1;
        end else begin
            if (dec == 1 && r_code < 255) r_code++;
            if (dec == -1 && r_code > 0) r_code--;
            same = (dec != 0) && (r_dir == 0 || r_dir == dec);
            if (same) begin
                if (r_run < UNLOCK_N) r_run++;
                r_lock_cnt = 0;
                if (r_run == UNLOCK_N) r_lock = 1'b0;
            end else begin
                if (r_lock_cnt < LOCK_N) r_lock_cnt++;
                r_run = 0;
                if (r_lock_cnt == LOCK_N) r_lock = 1'b1;
            end
            if (dec != 0) r_dir = dec;
        end
    endtask

    task automatic drive(input int mode, input int target);
        case (mode)
            MODE_SLOW: begin up_s = 1'b1; dn_s = 1'b0; end
            MODE_TARGET: begin up_s = (r_code < target); dn_s = (r_code > target); end
            MODE_DITHER: begin up_s = dither_up; dn_s = !dither_up; end
            MODE_BOTH: begin up_s = 1'b1; dn_s = 1'b1; end
            MODE_RANDOM: begin
                if ($urandom_range(0, 3) == 0) begin
                    up_s = 1'($urandom_range(0, 1));
                    dn_s = 1'($urandom_range(0, 1));
                end else begin
                    up_s = (r_code < target);
                    dn_s = (r_code > target);
                end
                if ($urandom_range(0, 299) == 0) m_s = 3'($urandom_range(0, 7));
            end
            default: begin up_s = 1'b0; dn_s = 1'b0; end
        endcase
    endtask

    task automatic run_edges(input int n, input int mode, input int target);
        for (int c = 0; c < n; c++) begin
            drive(mode, target);
            @(posedge clk);
            #1;
            model_edge(int'(m_s), up_s, dn_s);
            if (r_eval) dither_up = !dither_up;
            check("code", int'(code_o), r_code);
            check("lock", int'(lock_o), int'(r_lock));
            check("done", int'(done_o), int'(r_done));
        end
    endtask

    // Raise reset between edges, check the outputs respond before the next edge, then release.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_code", int'(code_o), 8'h80);
        check("async_rst_lock", int'(lock_o), 0);
        check("async_rst_done", int'(done_o), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset(int'(m_s));
    endtask

    initial begin
        int prev_mode;
        vecs[0]  = '{RS_NONE,  0, MODE_SLOW,   0,     31,   1, 8'hFF, 0, 0};
        vecs[1]  = '{RS_NONE,  0, MODE_SLOW,   0,     1,    1, 8'hFF, 0, 1};
        vecs[2]  = '{RS_NONE,  0, MODE_SLOW,   0,     40,   1, 8'hFF, 0, 1};
        vecs[3]  = '{RS_RESET, 0, MODE_TARGET, 8'h5A, 32,   1, 8'h5A, 0, 1};
        vecs[4]  = '{RS_NONE,  0, MODE_TARGET, 8'h5A, 31,   1, 8'h5A, 0, 1};
        vecs[5]  = '{RS_NONE,  0, MODE_TARGET, 8'h5A, 1,    1, 8'h5A, 1, 1};
        vecs[6]  = '{RS_NONE,  0, MODE_TARGET, 8'h70, 15,   1, 8'h5D, 1, 1};
        vecs[7]  = '{RS_NONE,  0, MODE_TARGET, 8'h70, 1,    1, 8'h5E, 0, 1};
        vecs[8]  = '{RS_NONE,  0, MODE_TARGET, 8'h70, 103,  1, 8'h70, 0, 1};
        vecs[9]  = '{RS_NONE,  0, MODE_TARGET, 8'h70, 1,    1, 8'h70, 1, 1};
        vecs[10] = '{RS_MCHG,  3, MODE_TARGET, 8'h70, 1,    1, 8'h80, 0, 0};
        vecs[11] = '{RS_NONE,  0, MODE_TARGET, 8'h70, 32,   1, 8'h70, 0, 1};
        vecs[12] = '{RS_NONE,  0, MODE_DITHER, 0,     35,   1, 8'h70, 0, 1};
        vecs[13] = '{RS_NONE,  0, MODE_DITHER, 0,     1,    1, 8'h71, 1, 1};
        vecs[14] = '{RS_NONE,  0, MODE_BOTH,   0,     40,   1, 8'h71, 1, 1};
        vecs[15] = '{RS_NONE,  0, MODE_RANDOM, 8'h40, 3000, 0, 0,     0, 0};

        rst  = 1'b1;
        m_s  = 3'd2;
        up_s = 1'b0;
        dn_s = 1'b0;
        dither_up = 1'b1;
        #29;
        check("reset_code", int'(code_o), 8'h80);
        check("reset_lock", int'(lock_o), 0);
        check("reset_done", int'(done_o), 0);
        #1;
        rst = 1'b0;
        model_reset(2);

        prev_mode = -1;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].restart == RS_RESET) pulse_reset();
            else if (vecs[i].restart == RS_MCHG) m_s = 3'(vecs[i].new_m);
            if (vecs[i].mode == MODE_DITHER && prev_mode != MODE_DITHER) dither_up = 1'b1;
            prev_mode = vecs[i].mode;
            run_edges(vecs[i].cycles, vecs[i].mode, vecs[i].target);
            if (vecs[i].chk_end != 0) begin
                check($sformatf("vec%0d_code", i), int'(code_o), vecs[i].exp_code);
                check($sformatf("vec%0d_lock", i), int'(lock_o), vecs[i].exp_lock);
                check($sformatf("vec%0d_done", i), int'(done_o), vecs[i].exp_done);
            end
        end

        // Acquire a low target, lock, then hit reset while locked in tracking.
        pulse_reset();
        run_edges(70, MODE_TARGET, 8'h33);
        check("low_target_code", int'(code_o), 8'h33);
        check("low_target_lock", int'(lock_o), 1);
        pulse_reset();

        // Fast-only drive: SAR goes to zero and tracking saturates there.
        run_edges(60, MODE_TARGET, -1);
        check("floor_code", int'(code_o), 8'h00);
        check("floor_lock", int'(lock_o), 0);
        check("floor_done", int'(done_o), 1);

        // M change landing exactly on a due decision edge takes priority.
        run_edges(3, MODE_SLOW, 0);
        m_s = m_s + 3'd1;
        run_edges(1, MODE_SLOW, 0);
        check("mchg_due_code", int'(code_o), 8'h80);
        check("mchg_due_done", int'(done_o), 0);
        run_edges(32, MODE_SLOW, 0);
        check("mchg_resar_code", int'(code_o), 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
